// File: rtl/spi_xip_pkg.sv
// spi_xip_pkg: shared states, SPI master register offsets and XIP constants
package spi_xip_pkg;
  typedef enum logic [3:0] {IDLE, PASS, WR_TX1, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX0, CLR_SS, RESP} state_t;
  localparam logic [4:0] ADR_RX0 = 5'h00;
  localparam logic [4:0] ADR_TX1 = 5'h04;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV = 5'h14;
  localparam logic [4:0] ADR_SS = 5'h18;
  localparam int CTRL_GO_BIT = 8;
  localparam logic [31:0] XIP_CTRL = 32'h140;
  localparam logic [7:0] READ_CMD = 8'h03;
  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
endpackage

// File: rtl/spi_xip_wb_req.sv
// spi_xip_wb_req: single registered Wishbone access, done pulses the cycle after ack/err
module spi_xip_wb_req (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  adr,
  input  logic [31:0] dat,
  input  logic [3:0]  sel,
  input  logic        we,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  // launch on start, hold the bus stable until ack/err, then drop and report
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      done <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        done <= 1'b1;
        rdata <= wb_dat_i;
        err <= wb_err_i;
      end else if (start && !wb_cyc_o) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_adr_o <= adr;
        wb_dat_o <= dat;
        wb_sel_o <= sel;
        wb_we_o <= we;
      end
    end
endmodule

// File: rtl/spi_xip_sequencer.sv
// spi_xip_sequencer: APB front end passing register accesses to spi_top and running XIP flash reads
module spi_xip_sequencer
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE = 32'h1000_1000,
  parameter logic [31:0] SPI_END = 32'h1000_1fff,
  parameter int SS_NUM = 8,
  parameter logic [31:0] DIVIDER = 32'h1,
  parameter logic [SS_NUM-1:0] FLASH_SS = 8'h01,
  parameter int POLL_MAX = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  localparam int PW = $clog2(POLL_MAX) + 1;
  state_t state, state_n;
  logic [PW-1:0] poll_cnt;
  logic [31:0] resp_data, wb_rdata, req_dat;
  logic resp_err, start, wb_done, wb_rerr, req_we, in_spi, in_flash, busy_go, timeout, fail;
  logic [4:0] req_adr;
  logic [3:0] req_sel;
  assign in_spi = in_paddr >= SPI_BASE && in_paddr <= SPI_END;
  assign in_flash = in_paddr >= FLASH_BASE && in_paddr <= FLASH_END;
  assign busy_go = wb_rdata[CTRL_GO_BIT];
  assign timeout = state == POLL && busy_go && poll_cnt == PW'(POLL_MAX - 1);
  assign fail = wb_rerr || timeout;
  assign start = state != IDLE && state != RESP && !wb_cyc_o && !wb_done;
  assign in_pready = state == RESP;
  assign in_prdata = in_pready ? resp_data : '0;
  assign in_pslverr = in_pready && resp_err;
  spi_xip_wb_req u_req (
    .clock(clock), .reset(reset), .start(start), .adr(req_adr), .dat(req_dat), .sel(req_sel), .we(req_we),
    .done(wb_done), .rdata(wb_rdata), .err(wb_rerr),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state and the Wishbone request for the current step
  always_comb begin
    state_n = state;
    req_adr = ADR_CTRL;
    req_dat = '0;
    req_sel = 4'hf;
    req_we = 1'b1;
    case (state)
      IDLE: if (in_psel && in_penable) state_n = in_spi ? PASS : (in_flash && !in_pwrite) ? WR_TX1 : RESP;
      PASS: begin
        req_adr = in_paddr[4:0];
        req_dat = in_pwdata;
        req_sel = in_pstrb;
        req_we = in_pwrite;
        if (wb_done) state_n = RESP;
      end
      WR_TX1: begin
        req_adr = ADR_TX1;
        req_dat = {READ_CMD, in_paddr[23:0]};
        if (wb_done) state_n = wb_rerr ? CLR_SS : WR_DIV;
      end
      WR_DIV: begin
        req_adr = ADR_DIV;
        req_dat = DIVIDER;
        if (wb_done) state_n = wb_rerr ? CLR_SS : WR_SS;
      end
      WR_SS: begin
        req_adr = ADR_SS;
        req_dat = 32'(FLASH_SS);
        if (wb_done) state_n = wb_rerr ? CLR_SS : WR_CTRL;
      end
      WR_CTRL: begin
        req_dat = XIP_CTRL;
        if (wb_done) state_n = wb_rerr ? CLR_SS : POLL;
      end
      POLL: begin
        req_we = 1'b0;
        if (wb_done) state_n = fail ? CLR_SS : busy_go ? POLL : RD_RX0;
      end
      RD_RX0: begin
        req_adr = ADR_RX0;
        req_we = 1'b0;
        if (wb_done) state_n = CLR_SS;
      end
      CLR_SS: begin
        req_adr = ADR_SS;
        if (wb_done) state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  // response data, sticky error and poll counter
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      poll_cnt <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else if (state == IDLE) begin
      poll_cnt <= '0;
      resp_data <= '0;
      resp_err <= !in_spi && !(in_flash && !in_pwrite);
    end else if (wb_done) begin
      if (state == PASS) begin
        resp_data <= wb_rdata;
        resp_err <= wb_rerr;
      end else if (fail) resp_err <= 1'b1;
      if (state == RD_RX0 && !wb_rerr) resp_data <= bswap(wb_rdata);
      if (state == POLL) poll_cnt <= poll_cnt + 1'b1;
    end
endmodule

// File: tb/tb_spi_xip_sequencer.sv
// tb_spi_xip_sequencer: directed checks of pass-through, XIP reads, errors, timeout and reset
module tb_spi_xip_sequencer;
  logic clock, reset;
  logic [31:0] in_paddr, in_pwdata, in_prdata, wb_dat_o, wb_dat_i;
  logic in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
  logic [3:0] in_pstrb, wb_sel_o;
  logic [4:0] wb_adr_o;
  logic wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
  logic stuck, err_en;
  logic [4:0] err_adr;
  logic [31:0] m_tx1, m_ctrl, m_ctrl_wr, m_div, m_ss, m_ss_set, m_rx0, lw_dat;
  logic [4:0] lw_adr;
  logic [3:0] lw_sel;
  int go_left;
  int polls = 0;
  int ctrl_writes = 0;
  int stb_pulses = 0;
  logic stb_d = 1'b0;
  int tests = 0;
  int fails = 0;
  spi_xip_sequencer dut (
    .clock(clock), .reset(reset), .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready),
    .in_prdata(in_prdata), .in_pslverr(in_pslverr), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // flash contents: 11 22 33 44 at 0x10..0x13, elsewhere address byte xor A5
  function automatic logic [7:0] fb(input logic [23:0] a);
    logic [7:0] k;
    k = 8'(a[1:0]) + 8'd1;
    return (a[23:2] == 22'd4) ? 8'h11 * k : a[7:0] ^ 8'hA5;
  endfunction
  // spi_top model: registered ack/err, GO busy for two polls unless stuck
  always @(posedge clock or posedge reset)
    if (reset) begin
      wb_ack_i <= 0; wb_err_i <= 0; wb_dat_i <= 0; m_tx1 <= 0; m_ctrl <= 0; m_ctrl_wr <= 0;
      m_div <= 0; m_ss <= 0; m_ss_set <= 0; m_rx0 <= 0; go_left <= 0; lw_adr <= 0; lw_sel <= 0; lw_dat <= 0;
    end else begin
      wb_ack_i <= 0;
      wb_err_i <= 0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        if (err_en && wb_adr_o == err_adr) wb_err_i <= 1;
        else begin
          wb_ack_i <= 1;
          wb_dat_i <= wb_adr_o == 5'h00 ? m_rx0 : wb_adr_o == 5'h10 ? m_ctrl : 32'h0;
          if (wb_we_o) begin
            lw_adr <= wb_adr_o; lw_sel <= wb_sel_o; lw_dat <= wb_dat_o;
            if (wb_adr_o == 5'h04) m_tx1 <= wb_dat_o;
            if (wb_adr_o == 5'h14) m_div <= wb_dat_o;
            if (wb_adr_o == 5'h18) begin
              m_ss <= wb_dat_o;
              if (wb_dat_o != 0) m_ss_set <= wb_dat_o;
            end
            if (wb_adr_o == 5'h10) begin
              m_ctrl <= wb_dat_o; m_ctrl_wr <= wb_dat_o; ctrl_writes <= ctrl_writes + 1;
              if (wb_dat_o[8]) begin
                go_left <= 2;
                m_rx0 <= {fb(m_tx1[23:0]), fb(m_tx1[23:0] + 24'd1), fb(m_tx1[23:0] + 24'd2), fb(m_tx1[23:0] + 24'd3)};
              end
            end
          end else if (wb_adr_o == 5'h10) begin
            polls <= polls + 1;
            if (!stuck) begin
              if (go_left <= 1) m_ctrl[8] <= 1'b0;
              go_left <= go_left - 1;
            end
          end
        end
      end
    end
  always @(posedge clock) begin
    stb_d <= wb_stb_o;
    if (wb_stb_o && !stb_d) stb_pulses <= stb_pulses + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic apb(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er, output int cy);
    @(posedge clock); #1;
    in_paddr = a; in_pwrite = w; in_pwdata = d; in_pstrb = s; in_psel = 1; in_penable = 0;
    @(posedge clock); #1;
    in_penable = 1;
    cy = 0;
    do begin
      @(posedge clock); #1;
      cy++;
    end while (!in_pready && cy < 10000);
    chk({tag, " pready"}, 32'(in_pready), 32'd1);
    rd = in_prdata;
    er = in_pslverr;
    in_psel = 0; in_penable = 0;
    @(posedge clock); #1;
    chk({tag, " pready pulse"}, 32'(in_pready), 32'd0);
  endtask
  logic [31:0] rd;
  logic er;
  int cy, p0, s0, c0, n;
  initial begin
    reset = 1; in_paddr = 0; in_pwdata = 0; in_pstrb = 0; in_psel = 0; in_penable = 0; in_pwrite = 0;
    stuck = 0; err_en = 0; err_adr = 0;
    #1;
    chk("rst pready", 32'(in_pready), 0);
    chk("rst prdata", in_prdata, 0);
    chk("rst pslverr", 32'(in_pslverr), 0);
    chk("rst cyc", 32'(wb_cyc_o), 0);
    chk("rst stb", 32'(wb_stb_o), 0);
    repeat (2) @(negedge clock);
    reset = 0;
    s0 = stb_pulses; p0 = polls;
    apb("t1", 32'h3000_0010, 0, 0, 4'hf, rd, er, cy);
    chk("t1 prdata", rd, 32'h4433_2211);
    chk("t1 pslverr", 32'(er), 0);
    chk("t1 tx1", m_tx1, 32'h0300_0010);
    chk("t1 ctrl", m_ctrl_wr, 32'h140);
    chk("t1 div", m_div, 32'h1);
    chk("t1 ss set", m_ss_set, 32'h1);
    chk("t1 ss clr", m_ss, 0);
    chk("t1 polls", 32'(polls - p0), 3);
    chk("t1 stb", 32'(stb_pulses - s0), 9);
    s0 = stb_pulses;
    apb("t2", 32'h1000_1014, 1, 32'h5, 4'hf, rd, er, cy);
    chk("t2 stb", 32'(stb_pulses - s0), 1);
    chk("t2 adr", 32'(lw_adr), 32'h14);
    chk("t2 sel", 32'(lw_sel), 32'hf);
    chk("t2 div", m_div, 32'h5);
    chk("t2 pslverr", 32'(er), 0);
    apb("t2b", 32'h1000_1004, 1, 32'hdead_beef, 4'h5, rd, er, cy);
    chk("t2b sel", 32'(lw_sel), 32'h5);
    chk("t2b tx1", m_tx1, 32'hdead_beef);
    apb("t2c", 32'h1000_1010, 0, 0, 4'hf, rd, er, cy);
    chk("t2c prdata", rd, 32'h40);
    chk("t2c pslverr", 32'(er), 0);
    s0 = stb_pulses;
    apb("t3", 32'h3000_0000, 1, 32'h1234, 4'hf, rd, er, cy);
    chk("t3 pslverr", 32'(er), 1);
    chk("t3 prdata", rd, 0);
    chk("t3 latency", 32'(cy), 1);
    chk("t3 stb", 32'(stb_pulses - s0), 0);
    err_en = 1; err_adr = 5'h00;
    apb("perr", 32'h1000_1000, 0, 0, 4'hf, rd, er, cy);
    chk("perr pslverr", 32'(er), 1);
    err_adr = 5'h14; s0 = stb_pulses; c0 = ctrl_writes;
    apb("xerr", 32'h3000_0010, 0, 0, 4'hf, rd, er, cy);
    chk("xerr pslverr", 32'(er), 1);
    chk("xerr stb", 32'(stb_pulses - s0), 3);
    chk("xerr ctrl", 32'(ctrl_writes - c0), 0);
    chk("xerr ss adr", 32'(lw_adr), 32'h18);
    chk("xerr ss dat", lw_dat, 0);
    err_en = 0;
    s0 = stb_pulses;
    apb("t6a", 32'h3fff_fffc, 0, 0, 4'hf, rd, er, cy);
    chk("t6a prdata", rd, 32'h5a5b_5859);
    chk("t6a pslverr", 32'(er), 0);
    chk("t6a tx1", m_tx1, 32'h03ff_fffc);
    chk("t6a stb", 32'(stb_pulses - s0), 9);
    s0 = stb_pulses;
    apb("t6b", 32'h4000_0000, 0, 0, 4'hf, rd, er, cy);
    chk("t6b pslverr", 32'(er), 1);
    chk("t6b prdata", rd, 0);
    apb("t6c", 32'h2fff_fffc, 0, 0, 4'hf, rd, er, cy);
    chk("t6c pslverr", 32'(er), 1);
    apb("t6d", 32'h1000_2000, 0, 0, 4'hf, rd, er, cy);
    chk("t6d pslverr", 32'(er), 1);
    chk("t6 stb", 32'(stb_pulses - s0), 0);
    apb("t6e", 32'h1000_1fff, 0, 0, 4'hf, rd, er, cy);
    chk("t6e pslverr", 32'(er), 0);
    stuck = 1; s0 = stb_pulses; p0 = polls;
    apb("t4", 32'h3000_0010, 0, 0, 4'hf, rd, er, cy);
    chk("t4 pslverr", 32'(er), 1);
    chk("t4 polls", 32'(polls - p0), 1024);
    chk("t4 ss clr", m_ss, 0);
    chk("t4 last adr", 32'(lw_adr), 32'h18);
    chk("t4 stb", 32'(stb_pulses - s0), 1029);
    p0 = polls;
    @(posedge clock); #1;
    in_paddr = 32'h3000_0010; in_pwrite = 0; in_psel = 1; in_penable = 0;
    @(posedge clock); #1;
    in_penable = 1;
    n = 0;
    while (polls - p0 < 5 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("t5 in poll", 32'(polls - p0 >= 5), 1);
    #3 reset = 1;
    #1;
    chk("t5 pready", 32'(in_pready), 0);
    chk("t5 prdata", in_prdata, 0);
    chk("t5 pslverr", 32'(in_pslverr), 0);
    chk("t5 cyc", 32'(wb_cyc_o), 0);
    chk("t5 stb", 32'(wb_stb_o), 0);
    chk("t5 we", 32'(wb_we_o), 0);
    chk("t5 adr", 32'(wb_adr_o), 0);
    chk("t5 dat", wb_dat_o, 0);
    chk("t5 sel", 32'(wb_sel_o), 0);
    in_psel = 0; in_penable = 0; stuck = 0;
    @(negedge clock);
    reset = 0;
    apb("t5b", 32'h3000_0010, 0, 0, 4'hf, rd, er, cy);
    chk("t5b prdata", rd, 32'h4433_2211);
    chk("t5b pslverr", 32'(er), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
